// File: rtl/nvdla_csb_arb_pkg.sv
// Shared types and widths for the NVDLA CSB two-requester arbiter.
package nvdla_csb_pkg;

    localparam int CSB_AW = 16;
    localparam int CSB_DW = 32;

    typedef struct packed {
        logic [CSB_AW-1:0] addr;
        logic [CSB_DW-1:0] wdat;
        logic              write;
        logic              nposted;
    } csb_req_t;

    typedef struct packed {
        logic id;
        logic is_read;
    } csb_rid_t;

    // Reads and non-posted writes expect a response and occupy an ID slot.
    function automatic logic needs_track(input csb_req_t r);
        return !r.write || r.nposted;
    endfunction

endpackage

// File: rtl/nvdla_csb_arb_if.sv
// Bundle of requester, core-request and core-response signals around the arbiter.
interface nvdla_csb_arb_if;
    import nvdla_csb_pkg::*;

    logic              m0_valid, m0_ready, m0_write, m0_nposted;
    logic [CSB_AW-1:0] m0_addr;
    logic [CSB_DW-1:0] m0_wdat;
    logic              m0_rvalid, m0_wr_complete;
    logic [CSB_DW-1:0] m0_rdata;

    logic              m1_valid, m1_ready, m1_write, m1_nposted;
    logic [CSB_AW-1:0] m1_addr;
    logic [CSB_DW-1:0] m1_wdat;
    logic              m1_rvalid, m1_wr_complete;
    logic [CSB_DW-1:0] m1_rdata;

    logic              csb2nvdla_valid, csb2nvdla_ready;
    logic [CSB_AW-1:0] csb2nvdla_addr;
    logic [CSB_DW-1:0] csb2nvdla_wdat;
    logic              csb2nvdla_write, csb2nvdla_nposted;

    logic              nvdla2csb_valid, nvdla2csb_wr_complete;
    logic [CSB_DW-1:0] nvdla2csb_data;

    logic              resp_err;

    modport slave (
        input  m0_valid, m0_addr, m0_wdat, m0_write, m0_nposted,
        input  m1_valid, m1_addr, m1_wdat, m1_write, m1_nposted,
        output m0_ready, m0_rvalid, m0_rdata, m0_wr_complete,
        output m1_ready, m1_rvalid, m1_rdata, m1_wr_complete,
        output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        input  csb2nvdla_ready,
        input  nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        output resp_err
    );

    modport master (
        output m0_valid, m0_addr, m0_wdat, m0_write, m0_nposted,
        output m1_valid, m1_addr, m1_wdat, m1_write, m1_nposted,
        input  m0_ready, m0_rvalid, m0_rdata, m0_wr_complete,
        input  m1_ready, m1_rvalid, m1_rdata, m1_wr_complete,
        input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        output csb2nvdla_ready,
        output nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        input  resp_err
    );

endinterface

// File: rtl/nvdla_csb_arb_id_fifo.sv
// In-order FIFO of {requester id, is_read} for outstanding response-bearing requests.
module nvdla_csb_id_fifo
    import nvdla_csb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     pclk,
    input  logic     prst,
    input  logic     push,
    input  csb_rid_t push_data,
    input  logic     pop,
    output csb_rid_t head,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    csb_rid_t        mem_q [DEPTH];
    csb_rid_t        mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge pclk or posedge prst) begin
            if (prst) mem_q[gi] <= '0;
            else      mem_q[gi] <= mem_d[gi];
        end
    end

endmodule

// File: rtl/nvdla_csb_arb.sv
// Round-robin arbiter of two CSB requesters onto the NVDLA core port, with
// grant lock under backpressure and in-order response routing.
module nvdla_csb_arb
    import nvdla_csb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               pclk,
    input  logic               prst,
    nvdla_csb_arb_if.slave     bus
);

    csb_req_t req0, req1, gnt_req;
    logic     track0, track1, elig0, elig1;
    logic     gnt, gnt_valid, issue_ok, hs;
    logic     rr_q, rr_d, lock_vld_q, lock_vld_d, lock_id_q, lock_id_d;
    logic     resp_err_q, resp_err_d;
    logic     fifo_full, fifo_empty, fifo_push, fifo_pop, resp_any, type_bad;
    csb_rid_t fifo_head, push_rid;

    always_comb begin
        req0   = '{addr: bus.m0_addr, wdat: bus.m0_wdat, write: bus.m0_write, nposted: bus.m0_nposted};
        req1   = '{addr: bus.m1_addr, wdat: bus.m1_wdat, write: bus.m1_write, nposted: bus.m1_nposted};
        track0 = needs_track(req0);
        track1 = needs_track(req1);
        elig0  = bus.m0_valid & (~track0 | ~fifo_full);
        elig1  = bus.m1_valid & (~track1 | ~fifo_full);
        if (lock_vld_q)         gnt = lock_id_q;
        else if (elig0 & elig1) gnt = rr_q;
        else                    gnt = elig1;
        gnt_req   = gnt ? req1 : req0;
        gnt_valid = gnt ? bus.m1_valid : bus.m0_valid;
        // Full is judged on the pre-pop count so ready never depends on a response.
        issue_ok  = ~prst & (~needs_track(gnt_req) | ~fifo_full);
    end

    assign bus.csb2nvdla_valid   = gnt_valid & issue_ok;
    assign bus.csb2nvdla_addr    = gnt_req.addr;
    assign bus.csb2nvdla_wdat    = gnt_req.wdat;
    assign bus.csb2nvdla_write   = gnt_req.write;
    assign bus.csb2nvdla_nposted = gnt_req.nposted;
    assign bus.m0_ready          = bus.csb2nvdla_ready & ~gnt & issue_ok;
    assign bus.m1_ready          = bus.csb2nvdla_ready &  gnt & issue_ok;
    assign hs                    = bus.csb2nvdla_valid & bus.csb2nvdla_ready;

    assign fifo_push = hs & needs_track(gnt_req);
    assign push_rid  = '{id: gnt, is_read: ~gnt_req.write};
    assign resp_any  = bus.nvdla2csb_valid | bus.nvdla2csb_wr_complete;
    assign fifo_pop  = resp_any & ~fifo_empty;
    assign type_bad  = fifo_head.is_read ? bus.nvdla2csb_wr_complete : bus.nvdla2csb_valid;

    assign bus.m0_rvalid      = fifo_pop & ~fifo_head.id & bus.nvdla2csb_valid;
    assign bus.m1_rvalid      = fifo_pop &  fifo_head.id & bus.nvdla2csb_valid;
    assign bus.m0_wr_complete = fifo_pop & ~fifo_head.id & bus.nvdla2csb_wr_complete;
    assign bus.m1_wr_complete = fifo_pop &  fifo_head.id & bus.nvdla2csb_wr_complete;
    assign bus.m0_rdata       = bus.nvdla2csb_data;
    assign bus.m1_rdata       = bus.nvdla2csb_data;
    assign bus.resp_err       = resp_err_q;

    always_comb begin
        rr_d       = hs ? ~gnt : rr_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (bus.csb2nvdla_valid & ~bus.csb2nvdla_ready) begin
            lock_vld_d = 1'b1;
            lock_id_d  = gnt;
        end else if (hs) begin
            lock_vld_d = 1'b0;
        end
        resp_err_d = resp_err_q | (resp_any & fifo_empty) | (fifo_pop & type_bad);
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            rr_q       <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            resp_err_q <= resp_err_d;
        end
    end

    nvdla_csb_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
        .pclk      (pclk),
        .prst      (prst),
        .push      (fifo_push),
        .push_data (push_rid),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_nvdla_csb_arb.sv
// Directed bench for nvdla_csb_arb: arbitration, lock, full FIFO, completions, errors, reset.
module tb_nvdla_csb_arb;

    logic pclk = 1'b0;
    logic prst;
    int   vectors = 0;
    int   errs    = 0;

    nvdla_csb_arb_if bus();

    nvdla_csb_arb #(.DEPTH(4)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic [15:0] a, input logic [31:0] d,
                          input logic w, input logic np);
        bus.m0_valid = v; bus.m0_addr = a; bus.m0_wdat = d; bus.m0_write = w; bus.m0_nposted = np;
    endtask

    task automatic set_m1(input logic v, input logic [15:0] a, input logic [31:0] d,
                          input logic w, input logic np);
        bus.m1_valid = v; bus.m1_addr = a; bus.m1_wdat = d; bus.m1_write = w; bus.m1_nposted = np;
    endtask

    initial begin
        prst = 1'b1;
        set_m0(0, 16'h0, 32'h0, 0, 0);
        set_m1(0, 16'h0, 32'h0, 0, 0);
        bus.csb2nvdla_ready       = 1'b1;
        bus.nvdla2csb_valid       = 1'b0;
        bus.nvdla2csb_wr_complete = 1'b0;
        bus.nvdla2csb_data        = 32'h55;
        #2;
        chk("rst_csb_valid", bus.csb2nvdla_valid, 1'b0);
        chk("rst_m0_ready", bus.m0_ready, 1'b0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chkw("rst_rdata_pass", bus.m1_rdata, 32'h55);
        step(); step();
        prst = 1'b0;

        // Simultaneous reads alternate m0, m1, m0, m1
        set_m0(1, 16'h0010, 32'h0, 0, 0);
        set_m1(1, 16'h0020, 32'h0, 0, 0);
        #1;
        chkw("rr1_addr", 32'(bus.csb2nvdla_addr), 32'h10);
        chk("rr1_m0_ready", bus.m0_ready, 1'b1);
        chk("rr1_m1_ready", bus.m1_ready, 1'b0);
        step();
        set_m0(1, 16'h0011, 32'h0, 0, 0);
        #1;
        chkw("rr2_addr", 32'(bus.csb2nvdla_addr), 32'h20);
        chk("rr2_m1_ready", bus.m1_ready, 1'b1);
        step();
        set_m1(1, 16'h0021, 32'h0, 0, 0);
        #1;
        chkw("rr3_addr", 32'(bus.csb2nvdla_addr), 32'h11);
        chk("rr3_m0_ready", bus.m0_ready, 1'b1);
        step();
        set_m0(0, 16'h0, 32'h0, 0, 0);
        #1;
        chkw("rr4_addr", 32'(bus.csb2nvdla_addr), 32'h21);
        chk("rr4_m1_ready", bus.m1_ready, 1'b1);
        step();
        set_m1(0, 16'h0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.nvdla2csb_valid = 1'b1;
            bus.nvdla2csb_data  = 32'hA + 32'(i);
            #1;
            chk("rsp_m0_rvalid", bus.m0_rvalid, (i % 2) == 0);
            chk("rsp_m1_rvalid", bus.m1_rvalid, (i % 2) == 1);
            chkw("rsp_rdata", bus.m0_rdata, 32'hA + 32'(i));
            step();
        end
        bus.nvdla2csb_valid = 1'b0;

        // Lock under backpressure: m1 write held, m0 arrives in cycle 2
        bus.csb2nvdla_ready = 1'b0;
        set_m1(1, 16'h0200, 32'h1234, 1, 0);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) set_m0(1, 16'h0100, 32'h0, 0, 0);
            #1;
            chkw("lock_addr", 32'(bus.csb2nvdla_addr), 32'h200);
            chk("lock_valid", bus.csb2nvdla_valid, 1'b1);
            step();
        end
        bus.csb2nvdla_ready = 1'b1;
        #1;
        chk("lock_m1_first", bus.m1_ready, 1'b1);
        chk("lock_m0_wait", bus.m0_ready, 1'b0);
        step();
        set_m1(0, 16'h0, 32'h0, 0, 0);
        #1;
        chkw("lock_m0_addr", 32'(bus.csb2nvdla_addr), 32'h100);
        chk("lock_m0_next", bus.m0_ready, 1'b1);
        step();
        set_m0(0, 16'h0, 32'h0, 0, 0);
        bus.nvdla2csb_valid = 1'b1;
        #1;
        chk("lock_rsp_m0", bus.m0_rvalid, 1'b1);
        step();
        bus.nvdla2csb_valid = 1'b0;

        // Full FIFO: four m0 reads, then m1 read stalls while a posted write passes
        for (int i = 0; i < 4; i++) begin
            set_m0(1, 16'h0030 + 16'(i), 32'h0, 0, 0);
            #1;
            chk("fill_m0_ready", bus.m0_ready, 1'b1);
            step();
        end
        set_m0(1, 16'h0050, 32'hCAFE, 1, 0);
        set_m1(1, 16'h0040, 32'h0, 0, 0);
        #1;
        chkw("full_posted_addr", 32'(bus.csb2nvdla_addr), 32'h50);
        chk("full_posted_ready", bus.m0_ready, 1'b1);
        chk("full_read_stall", bus.m1_ready, 1'b0);
        step();
        set_m0(0, 16'h0, 32'h0, 0, 0);
        #1;
        chk("full_no_valid", bus.csb2nvdla_valid, 1'b0);
        step();
        bus.nvdla2csb_valid = 1'b1;
        #1;
        chk("full_pop_rvalid", bus.m0_rvalid, 1'b1);
        chk("full_prepop_block", bus.m1_ready, 1'b0);
        step();
        bus.nvdla2csb_valid = 1'b0;
        #1;
        chk("full_m1_issue", bus.m1_ready, 1'b1);
        chkw("full_m1_addr", 32'(bus.csb2nvdla_addr), 32'h40);
        step();
        set_m1(0, 16'h0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.nvdla2csb_valid = 1'b1;
            #1;
            chk("drain_m1_rvalid", bus.m1_rvalid, i == 3);
            step();
        end
        bus.nvdla2csb_valid = 1'b0;

        // Non-posted write completion routes to m1 only
        set_m1(1, 16'h0123, 32'hDEADBEEF, 1, 1);
        #1;
        chk("np_nposted", bus.csb2nvdla_nposted, 1'b1);
        chk("np_write", bus.csb2nvdla_write, 1'b1);
        chkw("np_wdat", bus.csb2nvdla_wdat, 32'hDEADBEEF);
        chk("np_m1_ready", bus.m1_ready, 1'b1);
        step();
        set_m1(0, 16'h0, 32'h0, 0, 0);
        bus.nvdla2csb_wr_complete = 1'b1;
        #1;
        chk("np_m1_cmpl", bus.m1_wr_complete, 1'b1);
        chk("np_m0_cmpl", bus.m0_wr_complete, 1'b0);
        chk("np_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk("np_m1_rvalid", bus.m1_rvalid, 1'b0);
        step();
        bus.nvdla2csb_wr_complete = 1'b0;
        #1;
        chk("np_no_err", bus.resp_err, 1'b0);

        // Stray response with the FIFO empty
        bus.nvdla2csb_valid = 1'b1;
        #1;
        chk("stray_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk("stray_m1_rvalid", bus.m1_rvalid, 1'b0);
        step();
        bus.nvdla2csb_valid = 1'b0;
        step(); step();
        chk("stray_err_sticky", bus.resp_err, 1'b1);

        // Reset with two reads outstanding
        set_m0(1, 16'h0060, 32'h0, 0, 0);
        step();
        set_m0(1, 16'h0061, 32'h0, 0, 0);
        step();
        set_m0(1, 16'h0062, 32'h0, 0, 0);
        #1;
        prst = 1'b1;
        bus.nvdla2csb_valid = 1'b1;
        #1;
        chk("mid_rst_valid", bus.csb2nvdla_valid, 1'b0);
        chk("mid_rst_ready", bus.m0_ready, 1'b0);
        chk("mid_rst_err", bus.resp_err, 1'b0);
        chk("mid_rst_rvalid", bus.m0_rvalid, 1'b0);
        step();
        set_m0(0, 16'h0, 32'h0, 0, 0);
        prst = 1'b0;
        #1;
        chk("post_rst_rvalid", bus.m0_rvalid, 1'b0);
        step();
        bus.nvdla2csb_valid = 1'b0;
        #1;
        chk("post_rst_err", bus.resp_err, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
